// File: rtl/hls_deadlock_chan_monitor_pkg.sv
// hls_deadlock_pkg: shared constants, types and the per-channel info code for the deadlock monitor
package hls_deadlock_pkg;
    localparam int PERSIST_W = 8;
    typedef logic [PERSIST_W-1:0] persist_cnt_t;
    typedef logic [63:0] info_field_t;
    // One bit cleared per channel, position wrapping at the field width; caller truncates.
    function automatic info_field_t code(input int chan, input int info_w);
        return ~(info_field_t'(1) << (chan % info_w));
    endfunction
endpackage

// File: rtl/hls_deadlock_chan_monitor_if.sv
// hls_deadlock_chan_monitor_if: raw block/idle inputs and debug outputs of one deadlock monitor
interface hls_deadlock_chan_monitor_if #(
    parameter int NUM_CHAN = 8,
    parameter int NUM_INST = 1,
    parameter int INFO_W   = 8,
    parameter int IDX_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
);
    logic [NUM_CHAN-1:0]        axis_block_sigs;
    logic [NUM_INST-1:0]        inst_idle_sigs;
    logic [NUM_INST-1:0]        inst_block_sigs;
    logic                       clear;
    logic [NUM_CHAN*INFO_W-1:0] axis_block_info;
    logic                       block;
    logic [IDX_W-1:0]           first_chan;
    logic                       first_valid;
    logic [31:0]                block_cycles;
    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  axis_block_info, block, first_chan, first_valid, block_cycles
    );
    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output axis_block_info, block, first_chan, first_valid, block_cycles
    );
endinterface

// File: rtl/hls_deadlock_chan_monitor_persist_cnt.sv
// hls_deadlock_persist_cnt: confirms a channel once its block signal persists PERSIST_CYC cycles
module hls_deadlock_persist_cnt
    import hls_deadlock_pkg::*;
#(
    parameter int PERSIST_CYC = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic conf
);
    localparam persist_cnt_t P = persist_cnt_t'(PERSIST_CYC);
    persist_cnt_t cnt;
    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt <= '0;
        else        cnt <= sig ? ((cnt == P) ? cnt : cnt + 1'b1) : '0;
    // Confirms on the Nth high cycle itself, and for one more cycle after the drop when saturated.
    assign conf = (cnt == P - 1'b1 && sig) || cnt == P;
endmodule

// File: rtl/hls_deadlock_chan_monitor.sv
// hls_deadlock_chan_monitor: persistence-filtered deadlock detector with first-channel capture and
// a saturating blocked-cycle counter, optionally sticky until clear.
module hls_deadlock_chan_monitor
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_CHAN    = 8,
    parameter int NUM_INST    = 1,
    parameter int INFO_W      = 8,
    parameter int PERSIST_CYC = 1,
    parameter int STICKY      = 0,
    parameter int IDX_W       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input logic                        clock,
    input logic                        reset,
    hls_deadlock_chan_monitor_if.slave bus
);
    logic [NUM_CHAN-1:0]        conf;
    logic [NUM_CHAN*INFO_W-1:0] info_d, info_q;
    logic [IDX_W-1:0]           low_idx, fc_q;
    logic                       hit, block_q, fv_q;
    logic [31:0]                cyc_q;
    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        hls_deadlock_persist_cnt #(.PERSIST_CYC(PERSIST_CYC)) u_cnt (
            .clock(clock), .reset(reset), .sig(bus.axis_block_sigs[c]), .conf(conf[c])
        );
        assign info_d[c*INFO_W +: INFO_W] = conf[c] ? INFO_W'(code(c, INFO_W)) : '0;
    end
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) if (conf[i]) low_idx = IDX_W'(i);
    end
    assign hit = |conf || |(bus.inst_block_sigs & ~bus.inst_idle_sigs);
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            block_q <= 1'b0;
            info_q  <= '0;
            fc_q    <= '0;
            fv_q    <= 1'b0;
            cyc_q   <= '0;
        end else if (bus.clear) begin
            block_q <= 1'b0;
            info_q  <= '0;
            fc_q    <= '0;
            fv_q    <= 1'b0;
            cyc_q   <= '0;
        end else begin
            block_q <= (STICKY != 0) ? (block_q | hit) : hit;
            info_q  <= (STICKY != 0) ? (info_q | info_d) : info_d;
            cyc_q   <= (block_q && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;
            if (STICKY == 0 && !hit) fv_q <= 1'b0;
            else if (!fv_q && |conf) begin
                fv_q <= 1'b1;
                fc_q <= low_idx;
            end
        end
    assign bus.block           = block_q;
    assign bus.axis_block_info = block_q ? info_q : '0;
    assign bus.first_chan      = fc_q;
    assign bus.first_valid     = fv_q;
    assign bus.block_cycles    = cyc_q;
endmodule

// File: tb/tb_hls_deadlock_chan_monitor.sv
// tb_hls_deadlock_chan_monitor: four monitor configurations driven by shared directed vectors and
// checked every cycle against a run-length model, plus literal expectations.
module tb_hls_deadlock_chan_monitor;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [11:0] sig = '0;
    logic ib = 1'b0, ii = 1'b0, clr = 1'b0;

    hls_deadlock_chan_monitor_if #(.NUM_CHAN(8))  ifa();
    hls_deadlock_chan_monitor_if #(.NUM_CHAN(8))  ifb();
    hls_deadlock_chan_monitor_if #(.NUM_CHAN(8))  ifc();
    hls_deadlock_chan_monitor_if #(.NUM_CHAN(12)) ifd();

    hls_deadlock_chan_monitor #(.NUM_CHAN(8),  .PERSIST_CYC(1), .STICKY(0)) ua (.clock(clk), .reset(rst_n), .bus(ifa.slave));
    hls_deadlock_chan_monitor #(.NUM_CHAN(8),  .PERSIST_CYC(4), .STICKY(0)) ub (.clock(clk), .reset(rst_n), .bus(ifb.slave));
    hls_deadlock_chan_monitor #(.NUM_CHAN(8),  .PERSIST_CYC(1), .STICKY(1)) uc (.clock(clk), .reset(rst_n), .bus(ifc.slave));
    hls_deadlock_chan_monitor #(.NUM_CHAN(12), .PERSIST_CYC(2), .STICKY(1)) ud (.clock(clk), .reset(rst_n), .bus(ifd.slave));

    assign ifa.axis_block_sigs = sig[7:0];
    assign ifb.axis_block_sigs = sig[7:0];
    assign ifc.axis_block_sigs = sig[7:0];
    assign ifd.axis_block_sigs = sig;
    assign ifa.inst_block_sigs = ib; assign ifa.inst_idle_sigs = ii; assign ifa.clear = clr;
    assign ifb.inst_block_sigs = ib; assign ifb.inst_idle_sigs = ii; assign ifb.clear = clr;
    assign ifc.inst_block_sigs = ib; assign ifc.inst_idle_sigs = ii; assign ifc.clear = clr;
    assign ifd.inst_block_sigs = ib; assign ifd.inst_idle_sigs = ii; assign ifd.clear = clr;

    logic [95:0] d_info[4];
    logic        d_blk[4], d_fv[4];
    logic [3:0]  d_fc[4];
    logic [31:0] d_cyc[4];
    assign d_info[0] = 96'(ifa.axis_block_info); assign d_info[1] = 96'(ifb.axis_block_info);
    assign d_info[2] = 96'(ifc.axis_block_info); assign d_info[3] = 96'(ifd.axis_block_info);
    assign d_blk[0] = ifa.block; assign d_blk[1] = ifb.block; assign d_blk[2] = ifc.block; assign d_blk[3] = ifd.block;
    assign d_fv[0] = ifa.first_valid; assign d_fv[1] = ifb.first_valid;
    assign d_fv[2] = ifc.first_valid; assign d_fv[3] = ifd.first_valid;
    assign d_fc[0] = 4'(ifa.first_chan); assign d_fc[1] = 4'(ifb.first_chan);
    assign d_fc[2] = 4'(ifc.first_chan); assign d_fc[3] = ifd.first_chan;
    assign d_cyc[0] = ifa.block_cycles; assign d_cyc[1] = ifb.block_cycles;
    assign d_cyc[2] = ifc.block_cycles; assign d_cyc[3] = ifd.block_cycles;

    localparam int NC[4] = '{8, 8, 8, 12};
    localparam int PC[4] = '{1, 4, 1, 2};
    localparam int ST[4] = '{0, 0, 1, 1};

    // Model: per-channel run length of consecutive high cycles, plus the observable outputs.
    int          run[4][12];
    logic        m_blk[4], m_fv[4];
    logic [7:0]  m_info[4][12];
    int          m_fc[4];
    logic [31:0] m_cyc[4];
    int tests = 0, fails = 0;
    bit go = 0;

    task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [95:0] exp_info(input int d);
        logic [95:0] r = '0;
        for (int i = 0; i < NC[d]; i++) r[i*8 +: 8] = m_info[d][i];
        return m_blk[d] ? r : '0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_blk[d] = 0; m_fv[d] = 0; m_fc[d] = 0; m_cyc[d] = 0;
            for (int i = 0; i < 12; i++) begin run[d][i] = 0; m_info[d][i] = 0; end
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 4; d++) begin
            logic conf[12];
            bit any = 0, hit;
            int low = 0;
            for (int i = NC[d] - 1; i >= 0; i--) begin
                conf[i] = (sig[i] && run[d][i] >= PC[d] - 1) || run[d][i] >= PC[d];
                if (conf[i]) begin any = 1; low = i; end
                run[d][i] = sig[i] ? ((run[d][i] < 1000) ? run[d][i] + 1 : 1000) : 0;
            end
            hit = any || (ib && !ii);
            if (clr) begin
                m_blk[d] = 0; m_fv[d] = 0; m_fc[d] = 0; m_cyc[d] = 0;
                for (int i = 0; i < 12; i++) m_info[d][i] = 0;
            end else begin
                if (m_blk[d] && m_cyc[d] != 32'hFFFF_FFFF) m_cyc[d]++;
                m_blk[d] = ST[d] ? (m_blk[d] || hit) : hit;
                for (int i = 0; i < NC[d]; i++) begin
                    logic [7:0] cd = ~(8'd1 << (i % 8));
                    m_info[d][i] = (ST[d] ? m_info[d][i] : 8'h00) | (conf[i] ? cd : 8'h00);
                end
                if (!ST[d] && !hit) m_fv[d] = 0;
                else if (!m_fv[d] && any) begin m_fv[d] = 1; m_fc[d] = low; end
            end
        end
    endtask

    always @(negedge clk) if (go)
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("block[%0d]", d), 96'(d_blk[d]), 96'(m_blk[d]));
            chk($sformatf("first_valid[%0d]", d), 96'(d_fv[d]), 96'(m_fv[d]));
            chk($sformatf("block_cycles[%0d]", d), 96'(d_cyc[d]), 96'(m_cyc[d]));
            chk($sformatf("info[%0d]", d), d_info[d], exp_info(d));
            if (m_fv[d]) chk($sformatf("first_chan[%0d]", d), 96'(d_fc[d]), 96'(m_fc[d]));
        end

    task automatic step(input logic [11:0] s, input logic b = 0, input logic i_ = 0, input logic c = 0);
        @(negedge clk);
        #1 sig = s; ib = b; ii = i_; clr = c;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    initial begin
        model_reset();
        go = 1;
        repeat (2) @(negedge clk);
        chk("reset_block", 96'(d_blk[0]), 96'd0);
        rst_n = 1'b1;
        step(12'h000);
        // legacy timing: one-cycle pulse on channel 3
        step(12'h008);
        chk("t1_block", 96'(d_blk[0]), 96'd1);
        chk("t1_info", 96'(d_info[0][31:24]), 96'hF7);
        chk("t1_first", 96'(d_fc[0]), 96'd3);
        step(12'h000); step(12'h000);
        chk("t1_fall", 96'(d_blk[0]), 96'd0);
        chk("t1_fv_fall", 96'(d_fv[0]), 96'd0);
        step(12'h000, 0, 0, 1);
        // persistence filter on channel 5
        repeat (3) step(12'h020);
        step(12'h000); step(12'h000);
        chk("t2_short", 96'(d_blk[1]), 96'd0);
        repeat (3) step(12'h020);
        chk("t2_pre", 96'(d_blk[1]), 96'd0);
        step(12'h020);
        chk("t2_block", 96'(d_blk[1]), 96'd1);
        chk("t2_info", 96'(d_info[1][47:40]), 96'hDF);
        step(12'h000); step(12'h000, 0, 0, 1);
        // sticky capture of two simultaneous channels
        step(12'h044);
        chk("t3_first", 96'(d_fc[2]), 96'd2);
        chk("t3_info2", 96'(d_info[2][23:16]), 96'hFB);
        chk("t3_info6", 96'(d_info[2][55:48]), 96'hBF);
        repeat (3) step(12'h000);
        chk("t3_hold", 96'(d_blk[2]), 96'd1);
        chk("t3_cycles", 96'(d_cyc[2]), 96'd3);
        step(12'h000, 0, 0, 1);
        chk("t3_clr_block", 96'(d_blk[2]), 96'd0);
        chk("t3_clr_cycles", 96'(d_cyc[2]), 96'd0);
        chk("t3_clr_fc", 96'(d_fc[2]), 96'd0);
        // sub-instance block only
        step(12'h000, 1, 0);
        chk("t4_block", 96'(d_blk[0]), 96'd1);
        chk("t4_fv", 96'(d_fv[0]), 96'd0);
        chk("t4_info", d_info[0], 96'd0);
        step(12'h000, 1, 1);
        chk("t4_idle", 96'(d_blk[0]), 96'd0);
        step(12'h000, 0, 0, 1);
        // clear wins over a coincident confirm
        step(12'h002, 0, 0, 1);
        chk("t5_clr", 96'(d_blk[2]), 96'd0);
        step(12'h002);
        chk("t5_reflag", 96'(d_blk[2]), 96'd1);
        chk("t5_first", 96'(d_fc[2]), 96'd1);
        step(12'h000, 0, 0, 1);
        // wide instance, channel 9, then async reset mid-event
        step(12'h200); step(12'h200);
        chk("t6_block", 96'(d_blk[3]), 96'd1);
        chk("t6_info", 96'(d_info[3][79:72]), 96'hFD);
        chk("t6_first", 96'(d_fc[3]), 96'd9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_block", 96'(d_blk[3]), 96'd0);
        chk("t6_rst_info", d_info[3], 96'd0);
        chk("t6_rst_cycles", 96'(d_cyc[3]), 96'd0);
        chk("t6_rst_fv", 96'(d_fv[3]), 96'd0);
        model_reset();
        sig = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(12'h000); step(12'h000);
        chk("t6_release", 96'(d_blk[3]), 96'd0);
        step(12'h201); step(12'h201); step(12'h000); step(12'h000);
        go = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
